// File: rtl/matmul_stream_loader.sv
// Serial-to-parallel operand loader for the matrix-multiply core array.
// Packs a word stream into operands A and B, fires START, waits for DONE.
module matmul_stream_loader #(
    parameter int DWIDTH = 32,
    parameter int LANES  = 1024
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic [DWIDTH-1:0]         IN_DATA,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic                      DONE,
    output logic [DWIDTH*LANES-1:0]   STREAM_A,
    output logic [DWIDTH*LANES-1:0]   STREAM_B,
    output logic                      START,
    output logic                      BUSY,
    output logic [$clog2(LANES)-1:0]  LANE_IDX
);

    localparam int IW = $clog2(LANES);
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    typedef enum logic [1:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_FIRE,
        S_WAIT
    } state_t;

    state_t state;

    logic [LANES-1:0][DWIDTH-1:0] a_q;
    logic [LANES-1:0][DWIDTH-1:0] b_q;

    logic beat;

    assign IN_READY = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign START    = (state == S_FIRE);
    assign BUSY     = (state == S_FIRE) || (state == S_WAIT);
    assign beat     = IN_VALID && IN_READY;
    assign STREAM_A = a_q;
    assign STREAM_B = b_q;

    // Sequencer: lane writes, lane counter and load/fire/wait state.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state    <= S_LOAD_A;
            LANE_IDX <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            unique case (state)
                S_LOAD_A: begin
                    if (beat) begin
                        a_q[LANE_IDX] <= IN_DATA;
                        if (LANE_IDX == LAST) begin
                            LANE_IDX <= '0;
                            state    <= S_LOAD_B;
                        end else begin
                            LANE_IDX <= LANE_IDX + 1'b1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (beat) begin
                        b_q[LANE_IDX] <= IN_DATA;
                        if (LANE_IDX == LAST) begin
                            LANE_IDX <= '0;
                            state    <= S_FIRE;
                        end else begin
                            LANE_IDX <= LANE_IDX + 1'b1;
                        end
                    end
                end
                S_FIRE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (DONE) begin
                        state <= S_LOAD_A;
                    end
                end
                default: begin
                    state <= S_LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_stream_loader.sv
// Directed bench for matmul_stream_loader with DWIDTH=8, LANES=4.
// Table vectors cover streaming and DONE handling; resets are hand-driven.
module tb_matmul_stream_loader;

    localparam int DW = 8;
    localparam int LN = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          done;
    logic [31:0]   stream_a;
    logic [31:0]   stream_b;
    logic          start;
    logic          busy;
    logic [1:0]    lane_idx;

    int total = 0;
    int bad   = 0;

    matmul_stream_loader #(.DWIDTH(DW), .LANES(LN)) dut (
        .CLOCK    (clk),
        .RESET    (rst),
        .IN_DATA  (in_data),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .DONE     (done),
        .STREAM_A (stream_a),
        .STREAM_B (stream_b),
        .START    (start),
        .BUSY     (busy),
        .LANE_IDX (lane_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        dn;
        logic        rdy;
        logic        st;
        logic        bsy;
        logic [1:0]  idx;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic dn);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        done     = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic st,
                           input logic bsy, input logic [1:0] idx,
                           input logic [31:0] a, input logic [31:0] b);
        chk({tag, " ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, " start"}, 32'(start), 32'(st));
        chk({tag, " busy"}, 32'(busy), 32'(bsy));
        chk({tag, " idx"}, 32'(lane_idx), 32'(idx));
        chk({tag, " a"}, stream_a, a);
        chk({tag, " b"}, stream_b, b);
    endtask

    initial begin
        logic [31:0] ea;
        logic [31:0] eb;
        int          n;
        int          starts;
        logic        exp_st;

        // back-to-back load
        tbl.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h00000001, 32'h0});
        tbl.push_back('{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h00000201, 32'h0});
        tbl.push_back('{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'h00030201, 32'h0});
        tbl.push_back('{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h04030201, 32'h0});
        tbl.push_back('{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h04030201, 32'h00000005});
        tbl.push_back('{1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h04030201, 32'h00000605});
        tbl.push_back('{1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'h04030201, 32'h00070605});
        tbl.push_back('{1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h04030201, 32'h08070605});
        // 5 cycles of 0xFF offered while busy
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h04030201, 32'h08070605});
        tbl.push_back('{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h04030201, 32'h08070605});
        tbl.push_back('{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h040302AA, 32'h08070605});
        tbl.push_back('{1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0403BBAA, 32'h08070605});
        // spurious DONE in LOAD_A
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0403BBAA, 32'h08070605});
        tbl.push_back('{1'b1, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'h04CCBBAA, 32'h08070605});
        tbl.push_back('{1'b1, 8'hDD, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'hDDCCBBAA, 32'h08070605});
        tbl.push_back('{1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'hDDCCBBAA, 32'h08070621});
        tbl.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'hDDCCBBAA, 32'h08072221});
        tbl.push_back('{1'b1, 8'h23, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'hDDCCBBAA, 32'h08232221});
        tbl.push_back('{1'b1, 8'h24, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'hDDCCBBAA, 32'h24232221});
        // DONE during FIRE is ignored, honoured later in WAIT
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'hDDCCBBAA, 32'h24232221});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'hDDCCBBAA, 32'h24232221});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'hDDCCBBAA, 32'h24232221});

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        done     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("por", 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].dn);
            chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].st,
                    tbl[i].bsy, tbl[i].idx, tbl[i].a, tbl[i].b);
        end

        // six beats, then asynchronous reset mid-cycle
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'(8'h31 + i), 1'b0);
        chk_all("pre_rst", 1'b1, 1'b0, 1'b0, 2'd2, 32'h34333231, 32'h24233635);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        chk_all("late_done", 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

        // throttled reload 0x11..0x18, idle cycles carry junk data
        ea     = '0;
        eb     = '0;
        n      = 0;
        starts = 0;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                step(1'b0, 8'hEE, 1'b0);
                exp_st = 1'b0;
            end else begin
                step(1'b1, 8'(8'h11 + n), 1'b0);
                if (n < 4) ea[n*8 +: 8] = 8'(8'h11 + n);
                else       eb[(n-4)*8 +: 8] = 8'(8'h11 + n);
                n++;
                exp_st = (n == 8);
            end
            if (start) starts++;
            chk($sformatf("thr%0d start", i), 32'(start), 32'(exp_st));
            chk($sformatf("thr%0d idx", i), 32'(lane_idx), 32'(n % 4));
            chk($sformatf("thr%0d a", i), stream_a, ea);
            chk($sformatf("thr%0d b", i), stream_b, eb);
        end
        chk("thr final a", stream_a, 32'h14131211);
        chk("thr final b", stream_b, 32'h18171615);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h99, 1'b0);
            if (start) starts++;
            chk_all($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b1, 2'd0,
                    32'h14131211, 32'h18171615);
        end
        chk("start count", 32'(starts), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
